seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture_if.sv | 27 ++
 rtl/seg7_capture.sv | 143 ++++++++++++++
 tb/tb_seg7_capture.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Seven-segment capture bus.
// Groups the multiplexed display inputs (Salida, AN, clr) and the captured-digit
// results (digits, valid, dp, upd, upd_idx, err_pat, err_an).
//   master : drives the display bus and clr, observes the results (testbench side)
//   slave  : samples the display bus and clr, drives the results (seg7_capture)
interface seg7_capture_if;
    logic [7:0]  Salida;   // segments, active-low: [7]=a .. [1]=g, [0]=dp
    logic [7:0]  AN;       // anode strobes, active-low
    logic        clr;      // synchronous clear of captured state
    logic [31:0] digits;   // position i in [4i+3:4i]
    logic [7:0]  valid;
    logic [7:0]  dp;       // 1 = decimal point lit
    logic        upd;      // one-cycle commit pulse
    logic [2:0]  upd_idx;
    logic        err_pat;
    logic        err_an;

    modport master (
        output Salida, AN, clr,
        input  digits, valid, dp, upd, upd_idx, err_pat, err_an
    );

    modport slave (
        input  Salida, AN, clr,
        output digits, valid, dp, upd, upd_idx, err_pat, err_an
    );
endinterface

// File: rtl/seg7_capture.sv
// Captures the digits shown on a multiplexed, active-low seven-segment display.
// Both buses are double-synchronized; a digit is committed once segments and
// anodes have been identical for STABLE_CYC consecutive synchronized samples.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seg7_capture_if.slave (Salida/AN/clr in; digits/valid/dp/upd/upd_idx/
//          err_pat/err_an out)
module seg7_capture #(
    parameter int unsigned STABLE_CYC = 4  // legal 2..255
) (
    input logic           clk,
    input logic           rst,
    seg7_capture_if.slave bus
);
    localparam logic [7:0] CntMax = 8'(STABLE_CYC - 1);

    typedef enum logic [1:0] {StBlank, StSettle, StHeld} state_e;

    logic [7:0]  seg_m_q, seg_s_q, an_m_q, an_s_q;
    logic [15:0] prev_q;
    logic [7:0]  cnt_q;
    state_e      state_q;
    logic [31:0] digits_q;
    logic [7:0]  valid_q, dp_q;
    logic        upd_q;
    logic [2:0]  upd_idx_q;
    logic        err_pat_q, err_an_q;

    logic [7:0] an_low;
    logic       an_blank, an_onehot, an_multi;
    logic [2:0] an_idx;
    logic       chg, stable_max, commit;
    logic [3:0] code;
    logic       code_bad;

    always_comb begin
        an_low    = ~an_s_q;
        an_blank  = (an_low == 8'h00);
        an_onehot = !an_blank && ((an_low & (an_low - 8'd1)) == 8'h00);
        an_multi  = !an_blank && !an_onehot;
        an_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) an_idx = 3'(i);
        end
        chg        = ({seg_s_q, an_s_q} != prev_q);
        // Counter at its ceiling and no change this cycle: the current sample is
        // the STABLE_CYC-th identical one.
        stable_max = (cnt_q == CntMax) && !chg;
        commit     = (state_q == StSettle) && stable_max && an_onehot;
    end

    // Decode on a..g only; dp is captured separately.
    always_comb begin
        code_bad = 1'b0;
        case (seg_s_q[7:1])
            7'h01:        code = 4'd0;
            7'h4F:        code = 4'd1;
            7'h12:        code = 4'd2;
            7'h06:        code = 4'd3;
            7'h4C:        code = 4'd4;
            7'h24:        code = 4'd5;
            7'h20:        code = 4'd6;
            7'h0F:        code = 4'd7;
            7'h00:        code = 4'd8;
            7'h04, 7'h0C: code = 4'd9;  // nine with and without segment d
            default: begin
                code     = 4'hF;
                code_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m_q   <= 8'hFF;
            seg_s_q   <= 8'hFF;
            an_m_q    <= 8'hFF;
            an_s_q    <= 8'hFF;
            prev_q    <= 16'hFFFF;
            cnt_q     <= 8'd0;
            state_q   <= StBlank;
            digits_q  <= 32'd0;
            valid_q   <= 8'd0;
            dp_q      <= 8'd0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            err_pat_q <= 1'b0;
            err_an_q  <= 1'b0;
        end else begin
            seg_m_q <= bus.Salida;
            seg_s_q <= seg_m_q;
            an_m_q  <= bus.AN;
            an_s_q  <= an_m_q;
            prev_q  <= {seg_s_q, an_s_q};

            if (chg) begin
                cnt_q <= 8'd0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (an_blank || an_multi) begin
                state_q <= StBlank;
            end else begin
                case (state_q)
                    StBlank:  state_q <= StSettle;
                    StSettle: if (commit) state_q <= StHeld;
                    StHeld:   if (chg) state_q <= StSettle;
                    default:  state_q <= StBlank;
                endcase
            end

            upd_q <= 1'b0;
            if (bus.clr) begin
                // Clear wins over a coincident commit; that commit is lost.
                digits_q  <= 32'd0;
                valid_q   <= 8'd0;
                dp_q      <= 8'd0;
                err_pat_q <= 1'b0;
                err_an_q  <= 1'b0;
            end else begin
                if (commit) begin
                    digits_q[{an_idx, 2'b00} +: 4] <= code;
                    valid_q[an_idx]                <= 1'b1;
                    dp_q[an_idx]                   <= ~seg_s_q[0];
                    upd_idx_q                      <= an_idx;
                    upd_q                          <= 1'b1;
                    if (code_bad) err_pat_q <= 1'b1;
                end
                if (stable_max && an_multi) err_an_q <= 1'b1;
            end
        end
    end

    assign bus.digits  = digits_q;
    assign bus.valid   = valid_q;
    assign bus.dp      = dp_q;
    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
    assign bus.err_pat = err_pat_q;
    assign bus.err_an  = err_an_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Testbench for seg7_capture: scenario tasks with inline checks, plus a
// scoreboard of expected commits popped whenever upd pulses.
module tb_seg7_capture;
    localparam int unsigned StableCyc = 4;

    logic clk = 1'b0;
    logic rst;

    seg7_capture_if bus();

    seg7_capture #(.STABLE_CYC(StableCyc)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] code;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   upd_seen = 0;

    // Segment patterns for digits 0..7 with dp off.
    logic [7:0] pat [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

    // Commit monitor: every upd pulse must match the oldest expected commit.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.upd) begin
            upd_seen++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: pulse with upd_idx=%0d, expected no pulse",
                         bus.upd_idx);
            end else begin
                e = sb_q.pop_front();
                if (bus.upd_idx !== e.idx || bus.digits[4*e.idx +: 4] !== e.code ||
                    bus.dp[e.idx] !== e.dp || bus.valid[e.idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL commit: got idx=%0d code=%h dp=%b valid=%b, want idx=%0d code=%h dp=%b valid=1",
                             bus.upd_idx, bus.digits[4*e.idx +: 4], bus.dp[e.idx],
                             bus.valid[e.idx], e.idx, e.code, e.dp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] seg);
        bus.AN     = an;
        bus.Salida = seg;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clr = 1'b0;
        drive(8'hFF, 8'hFF);
        #12;
        checks++;
        if ({bus.digits, bus.valid, bus.dp, bus.upd, bus.upd_idx, bus.err_pat, bus.err_an}
            !== 61'd0) begin
            errors++;
            $display("FAIL reset_outputs: got digits=%h valid=%h dp=%h upd=%b, want all zero",
                     bus.digits, bus.valid, bus.dp, bus.upd);
        end
        @(negedge clk);
        rst = 1'b0;
        hold(3);
        checks++;
        if (bus.valid !== 8'h00 || bus.upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%h upd=%b, want 00 0", bus.valid, bus.upd);
        end
    endtask

    task automatic test_single();
        int base;
        base = upd_seen;
        drive(8'hFE, 8'h9F);
        sb_q.push_back('{idx: 3'd0, code: 4'd1, dp: 1'b0});
        // k counts edges from the first one that samples the new inputs (k=1).
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.upd !== (k == StableCyc + 3)) begin
                errors++;
                $display("FAIL single_upd_timing k=%0d: got upd=%b, want %b",
                         k, bus.upd, (k == StableCyc + 3));
            end
        end
        checks++;
        if (bus.digits[3:0] !== 4'd1 || bus.valid !== 8'h01 || bus.dp[0] !== 1'b0 ||
            upd_seen - base != 1) begin
            errors++;
            $display("FAIL single_state: got d0=%h valid=%h dp0=%b pulses=%0d, want 1 01 0 1",
                     bus.digits[3:0], bus.valid, bus.dp[0], upd_seen - base);
        end
        hold(1);
    endtask

    task automatic test_cycle();
        int base;
        base = upd_seen;
        for (int p = 0; p < 8; p++) begin
            drive(~(8'h01 << p), pat[p]);
            sb_q.push_back('{idx: 3'(p), code: 4'(p), dp: 1'b0});
            hold(10);
        end
        checks++;
        if (bus.digits !== 32'h76543210 || bus.valid !== 8'hFF || upd_seen - base != 8) begin
            errors++;
            $display("FAIL cycle: got digits=%h valid=%h pulses=%0d, want 76543210 FF 8",
                     bus.digits, bus.valid, upd_seen - base);
        end
    endtask

    task automatic test_toggle();
        int base;
        base = upd_seen;
        drive(8'hFD, 8'h9F);
        for (int t = 0; t < 6; t++) begin
            hold(2);
            bus.Salida = (bus.Salida == 8'h9F) ? 8'h25 : 8'h9F;
        end
        hold(2);
        checks++;
        if (upd_seen != base || bus.digits[7:4] !== 4'd1) begin
            errors++;
            $display("FAIL toggle_no_commit: got pulses=%0d d1=%h, want 0 1",
                     upd_seen - base, bus.digits[7:4]);
        end
        bus.Salida = 8'h25;
        sb_q.push_back('{idx: 3'd1, code: 4'd2, dp: 1'b0});
        hold(10);
        checks++;
        if (bus.digits[7:4] !== 4'd2) begin
            errors++;
            $display("FAIL toggle_then_hold: got d1=%h, want 2", bus.digits[7:4]);
        end
    endtask

    task automatic test_errors();
        int base;
        logic [31:0] d0;
        base = upd_seen;
        d0   = bus.digits;
        drive(8'hFC, 8'h25);
        hold(10);
        checks++;
        if (bus.err_an !== 1'b1 || upd_seen != base || bus.digits !== d0 ||
            bus.err_pat !== 1'b0) begin
            errors++;
            $display("FAIL err_an: got err_an=%b pulses=%0d digits=%h err_pat=%b, want 1 0 %h 0",
                     bus.err_an, upd_seen - base, bus.digits, bus.err_pat, d0);
        end
        drive(8'hFE, 8'hFF);
        sb_q.push_back('{idx: 3'd0, code: 4'hF, dp: 1'b0});
        hold(10);
        checks++;
        if (bus.digits[3:0] !== 4'hF || bus.err_pat !== 1'b1) begin
            errors++;
            $display("FAIL err_pat: got d0=%h err_pat=%b, want F 1",
                     bus.digits[3:0], bus.err_pat);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        drive(8'hFB, 8'h0D);
        hold(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.digits, bus.valid, bus.dp, bus.upd, bus.upd_idx, bus.err_pat, bus.err_an}
            !== 61'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got digits=%h valid=%h err_an=%b, want all zero",
                     bus.digits, bus.valid, bus.err_an);
        end
        #7;
        rst = 1'b0;  // released 1 ns before the next edge
        base = upd_seen;
        sb_q.push_back('{idx: 3'd2, code: 4'd3, dp: 1'b0});
        // k = 0 is the first edge after release.
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.upd !== (k == StableCyc + 2)) begin
                errors++;
                $display("FAIL reset_mid_timing k=%0d: got upd=%b, want %b",
                         k, bus.upd, (k == StableCyc + 2));
            end
        end
        checks++;
        if (bus.valid !== 8'h04 || upd_seen - base != 1) begin
            errors++;
            $display("FAIL reset_mid_state: got valid=%h pulses=%0d, want 04 1",
                     bus.valid, upd_seen - base);
        end
        hold(1);
    endtask

    task automatic test_clr();
        int base;
        base = upd_seen;
        drive(8'hF7, 8'h19);
        hold(StableCyc + 2);
        bus.clr = 1'b1;  // sampled on the commit edge
        hold(1);
        bus.clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.upd !== 1'b0 || bus.valid !== 8'h00 || bus.digits !== 32'd0 ||
            upd_seen != base) begin
            errors++;
            $display("FAIL clr_wins: got upd=%b valid=%h digits=%h pulses=%0d, want 0 00 0 0",
                     bus.upd, bus.valid, bus.digits, upd_seen - base);
        end
        hold(1);
        drive(8'hF7, 8'h09);
        sb_q.push_back('{idx: 3'd3, code: 4'd9, dp: 1'b0});
        hold(10);
        checks++;
        if (bus.digits[15:12] !== 4'd9 || bus.valid !== 8'h08) begin
            errors++;
            $display("FAIL clr_recommit: got d3=%h valid=%h, want 9 08",
                     bus.digits[15:12], bus.valid);
        end
        drive(8'hEF, 8'h18);
        sb_q.push_back('{idx: 3'd4, code: 4'd9, dp: 1'b1});
        hold(10);
        checks++;
        if (bus.digits[19:16] !== 4'd9 || bus.dp !== 8'h10 || bus.valid !== 8'h18) begin
            errors++;
            $display("FAIL nine_dp: got d4=%h dp=%h valid=%h, want 9 10 18",
                     bus.digits[19:16], bus.dp, bus.valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cycle();
        test_toggle();
        test_errors();
        test_reset_mid();
        test_clr();
        hold(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending commits, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
